// File: rtl/chmu_axis_pkg.sv
// Shared types for the CHMU hot-address stream packer: lane-count helper, lane index type, FSM states.
package chmu_axis_pkg;

  function automatic int packer_lanes(input int out_w, input int data_w);
    return out_w / data_w;
  endfunction

  localparam int DEF_LANES = packer_lanes(512, 32);

  typedef logic [$clog2(DEF_LANES+1)-1:0] lane_idx_t;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } packer_state_e;

endpackage

// File: rtl/axis_packer_idle_timer.sv
// Saturating idle counter: clear wins over enable, o_timeout flags the cycle whose increment reaches TIMEOUT.
// TIMEOUT == 0 keeps o_timeout low permanently.
module axis_packer_idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires one edge early so the flush lands on the edge where the count hits TIMEOUT.
  assign o_timeout = (TIMEOUT != 0) && i_en && (r_cnt >= LAST);

endmodule

// File: rtl/axis_addr_packer.sv
// Packs LANES address beats into one record; partial records flush on flush_req or idle timeout. Optional AXIS_PACKER_DEDUP_EN drops repeated beats.
// Latency: last beat (or flush) to m_axis_tvalid is 1 cycle through a single output slot register.
// Backpressure: s_axis_tready drops while a full or pending-flush record waits for the output slot to free.
module axis_addr_packer
  import chmu_axis_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OUT_WIDTH      = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LANES         = packer_lanes(OUT_WIDTH, DATA_WIDTH)
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  flush_req,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic [LANES-1:0]      m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           rec_count
`ifdef AXIS_PACKER_DEDUP_EN
  ,
  output logic [31:0]           dup_count
`endif
);

  localparam int LW = $clog2(LANES + 1);
  typedef logic [LW-1:0] cnt_t;

  packer_state_e        r_state, w_state_nxt;
  cnt_t                 r_lane_cnt, w_cnt_nxt;
  logic [OUT_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [LANES-1:0]     w_keep;
  logic                 r_pend, w_pend_nxt;
  logic                 r_m_vld;
  logic [OUT_WIDTH-1:0] r_m_dat;
  logic [LANES-1:0]     r_m_keep;
  logic [31:0]          r_rec_cnt;
  logic                 w_slot_free, w_accept, w_write, w_dup, w_timeout;
  logic                 w_full_nxt, w_flush_cond, w_load, w_timer_en, w_timer_clr;

  assign w_slot_free   = ~r_m_vld | m_axis_tready;
  assign s_axis_tready = (r_state == FILL) & ~r_pend & ~s_axis_areset;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_write       = w_accept & ~w_dup;
  assign w_cnt_nxt     = r_lane_cnt + cnt_t'(w_write);
  assign w_full_nxt    = (w_cnt_nxt == cnt_t'(LANES));
  // Flush sees the lane count including a beat accepted this cycle.
  assign w_flush_cond  = (flush_req | w_timeout | r_pend) & (w_cnt_nxt != '0);
  assign w_load        = w_slot_free & (w_full_nxt | w_flush_cond);
  assign w_timer_en    = (r_lane_cnt != '0) & ~w_accept;
  assign w_timer_clr   = w_accept | w_load;

  axis_packer_idle_timer #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk     (s_axis_aclk),
    .i_rst     (s_axis_areset),
    .i_clr     (w_timer_clr),
    .i_en      (w_timer_en),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_acc_nxt = r_acc;
    w_keep    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_write && (r_lane_cnt == cnt_t'(i))) begin
        w_acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
      end
      w_keep[i] = (cnt_t'(i) < w_cnt_nxt);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    if (w_load) begin
      w_state_nxt = FILL;
      w_pend_nxt  = 1'b0;
    end else begin
      if (w_full_nxt) begin
        w_state_nxt = STALL;
      end
      if ((flush_req | w_timeout) && (w_cnt_nxt != '0) && !w_full_nxt) begin
        w_pend_nxt = 1'b1;
      end
    end
  end

  // The accumulator is zeroed on every load so unfilled lanes of a partial record read as 0.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_state    <= FILL;
      r_pend     <= 1'b0;
      r_lane_cnt <= '0;
      r_acc      <= '0;
      r_m_vld    <= 1'b0;
      r_m_dat    <= '0;
      r_m_keep   <= '0;
      r_rec_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_lane_cnt <= w_load ? '0 : w_cnt_nxt;
      r_acc      <= w_load ? '0 : w_acc_nxt;
      if (w_load) begin
        r_m_vld  <= 1'b1;
        r_m_dat  <= w_acc_nxt;
        r_m_keep <= w_keep;
      end else if (m_axis_tready) begin
        r_m_vld  <= 1'b0;
      end
      if (r_m_vld && m_axis_tready) begin
        r_rec_cnt <= r_rec_cnt + 32'd1;
      end
    end
  end

`ifdef AXIS_PACKER_DEDUP_EN
  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_last_vld;
  logic [31:0]           r_dup_cnt;

  assign w_dup     = r_last_vld & (s_axis_tdata == r_last);
  assign dup_count = r_dup_cnt;

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_dup_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_last_vld <= 1'b0;
      end else if (w_accept) begin
        r_last     <= s_axis_tdata;
        r_last_vld <= 1'b1;
      end
      if (w_accept && w_dup) begin
        r_dup_cnt <= r_dup_cnt + 32'd1;
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign m_axis_tvalid = r_m_vld;
  assign m_axis_tdata  = r_m_dat;
  assign m_axis_tkeep  = r_m_keep;
  assign rec_count     = r_rec_cnt;

endmodule
